// File: rtl/tcp_tuple_extractor.sv
// Pass-through NetFPGA stage that forwards every word and extracts the TCP 4-tuple plus
// flags of IPv4/TCP packets into a first-word-fall-through tuple FIFO.
module tcp_tuple_extractor #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int IN_FIFO_BITS    = 3,
  parameter int TUPLE_FIFO_BITS = 2,
  parameter int DIR_MODE        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  tuple_valid,
  input  logic                  tuple_ready,
  output logic [95:0]           tuple_data,
  output logic [7:0]            tuple_flags,
  output logic                  tuple_swapped,
  output logic [31:0]           num_tcp,
  output logic [31:0]           num_tuples,
  output logic [31:0]           num_drops,
  output logic [31:0]           num_opt_skip
);

  localparam int IN_W     = CTRL_WIDTH + DATA_WIDTH;
  localparam int IN_DEPTH = 2 ** IN_FIFO_BITS;
  localparam int T_W      = 105;
  localparam int T_DEPTH  = 2 ** TUPLE_FIFO_BITS;
  localparam logic [IN_FIFO_BITS:0]    IN_FULL = {1'b1, {IN_FIFO_BITS{1'b0}}};
  localparam logic [TUPLE_FIFO_BITS:0] T_FULL  = {1'b1, {TUPLE_FIFO_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_HDR, S_W2, S_W3, S_W4, S_W5, S_W6, S_SKIP, S_OPT
  } state_t;

  logic [IN_W-1:0]         in_mem [IN_DEPTH];
  logic [IN_FIFO_BITS-1:0] in_wptr, in_rptr;
  logic [IN_FIFO_BITS:0]   in_count;
  logic                    in_push, in_empty, rd_en;

  logic [T_W-1:0]             t_mem [T_DEPTH];
  logic [TUPLE_FIFO_BITS-1:0] t_wptr, t_rptr;
  logic [TUPLE_FIFO_BITS:0]   t_count;
  logic                       t_empty, t_full, t_pop, t_push, t_drop;

  state_t         state, state_next;
  logic           is_ctrl, is_ipv4, tcp_hit, opt_hit, cap_w4, cap_w5, cap_w6, swap;
  logic [31:0]    src_ip, dst_ip;
  logic [15:0]    src_port, dst_port;
  logic           push_req;
  logic [T_W-1:0] push_entry, entry;

  assign in_empty = (in_count == {(IN_FIFO_BITS+1){1'b0}});
  assign in_rdy   = (in_count != IN_FULL);
  assign in_push  = in_wr && in_rdy;
  assign rd_en    = !in_empty && out_rdy;
  assign out_wr   = rd_en;
  assign {out_ctrl, out_data} = in_mem[in_rptr];

  // Input FIFO storage
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem[in_wptr] <= {in_ctrl, in_data};
    end
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      in_wptr  <= {IN_FIFO_BITS{1'b0}};
      in_rptr  <= {IN_FIFO_BITS{1'b0}};
      in_count <= {(IN_FIFO_BITS+1){1'b0}};
    end else begin
      if (in_push) in_wptr <= in_wptr + IN_FIFO_BITS'(1'b1);
      if (rd_en)   in_rptr <= in_rptr + IN_FIFO_BITS'(1'b1);
      case ({in_push, rd_en})
        2'b10:   in_count <= in_count + (IN_FIFO_BITS+1)'(1'b1);
        2'b01:   in_count <= in_count - (IN_FIFO_BITS+1)'(1'b1);
        default: in_count <= in_count;
      endcase
    end
  end

  assign is_ctrl = (out_ctrl != {CTRL_WIDTH{1'b0}});
  assign is_ipv4 = (out_data[31:16] == 16'h0800) && (out_data[15:12] == 4'd4);

  // Parser next state; only a forwarded word advances it
  always_comb begin
    state_next = state;
    tcp_hit    = 1'b0;
    opt_hit    = 1'b0;
    cap_w4     = 1'b0;
    cap_w5     = 1'b0;
    cap_w6     = 1'b0;
    if (rd_en) begin
      case (state)
        S_HDR:  if (is_ctrl) state_next = S_HDR; else state_next = S_W2;
        S_W2: begin
          if (is_ctrl)                                state_next = S_HDR;
          else if (is_ipv4 && out_data[11:8] == 4'd5) state_next = S_W3;
          else if (is_ipv4)                           state_next = S_OPT;
          else                                        state_next = S_SKIP;
        end
        S_OPT: begin
          if (is_ctrl) begin
            state_next = S_HDR;
          end else begin
            state_next = S_SKIP;
            opt_hit    = (out_data[7:0] == 8'h06);
          end
        end
        S_W3: begin
          if (is_ctrl) begin
            state_next = S_HDR;
          end else if (out_data[7:0] == 8'h06) begin
            state_next = S_W4;
            tcp_hit    = 1'b1;
          end else begin
            state_next = S_SKIP;
          end
        end
        S_W4: begin
          if (is_ctrl) begin
            state_next = S_HDR;
          end else begin
            state_next = S_W5;
            cap_w4     = 1'b1;
          end
        end
        S_W5: begin
          if (is_ctrl) begin
            state_next = S_HDR;
          end else begin
            state_next = S_W6;
            cap_w5     = 1'b1;
          end
        end
        S_W6: begin
          cap_w6 = 1'b1;
          if (is_ctrl) state_next = S_HDR; else state_next = S_SKIP;
        end
        S_SKIP: if (is_ctrl) state_next = S_HDR; else state_next = S_SKIP;
        default: state_next = S_HDR;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Parser state and captured header fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HDR;
      src_ip   <= 32'h0;
      dst_ip   <= 32'h0;
      src_port <= 16'h0;
      dst_port <= 16'h0;
    end else begin
      state <= state_next;
      if (cap_w4) begin
        src_ip         <= out_data[47:16];
        dst_ip[31:16]  <= out_data[15:0];
      end
      if (cap_w5) begin
        dst_ip[15:0] <= out_data[63:48];
        src_port     <= out_data[47:32];
        dst_port     <= out_data[31:16];
      end
    end
  end

  // Endpoint ordering; flags byte is the low byte of the current word, ACK is bit 4
  always_comb begin
    swap = 1'b0;
    case (DIR_MODE)
      32'sd0:  swap = 1'b0;
      32'sd1:  swap = out_data[4];
      32'sd2:  swap = ({src_ip, src_port} > {dst_ip, dst_port});
      default: swap = 1'b0;
    endcase
    if (swap) begin
      entry = {1'b1, out_data[7:0], dst_ip, src_ip, dst_port, src_port};
    end else begin
      entry = {1'b0, out_data[7:0], src_ip, dst_ip, src_port, dst_port};
    end
  end

  // Registered push request, issued the cycle after word 6 is forwarded
  always_ff @(posedge clk) begin
    if (reset) begin
      push_req   <= 1'b0;
      push_entry <= {T_W{1'b0}};
    end else begin
      push_req <= cap_w6;
      if (cap_w6) push_entry <= entry;
    end
  end

  assign t_empty = (t_count == {(TUPLE_FIFO_BITS+1){1'b0}});
  assign t_full  = (t_count == T_FULL);
  assign t_pop   = !t_empty && tuple_ready;
  assign t_push  = push_req && (!t_full || t_pop);
  assign t_drop  = push_req && t_full && !t_pop;

  // Tuple FIFO storage
  always_ff @(posedge clk) begin
    if (t_push) begin
      t_mem[t_wptr] <= push_entry;
    end
  end

  // Tuple FIFO pointers, occupancy and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      t_wptr       <= {TUPLE_FIFO_BITS{1'b0}};
      t_rptr       <= {TUPLE_FIFO_BITS{1'b0}};
      t_count      <= {(TUPLE_FIFO_BITS+1){1'b0}};
      num_tcp      <= 32'h0;
      num_tuples   <= 32'h0;
      num_drops    <= 32'h0;
      num_opt_skip <= 32'h0;
    end else begin
      if (t_push) t_wptr <= t_wptr + TUPLE_FIFO_BITS'(1'b1);
      if (t_pop)  t_rptr <= t_rptr + TUPLE_FIFO_BITS'(1'b1);
      case ({t_push, t_pop})
        2'b10:   t_count <= t_count + (TUPLE_FIFO_BITS+1)'(1'b1);
        2'b01:   t_count <= t_count - (TUPLE_FIFO_BITS+1)'(1'b1);
        default: t_count <= t_count;
      endcase
      if (tcp_hit) num_tcp      <= num_tcp + 32'd1;
      if (t_push)  num_tuples   <= num_tuples + 32'd1;
      if (t_drop)  num_drops    <= num_drops + 32'd1;
      if (opt_hit) num_opt_skip <= num_opt_skip + 32'd1;
    end
  end

  assign tuple_valid = !t_empty;
  assign {tuple_swapped, tuple_flags, tuple_data} = t_empty ? {T_W{1'b0}} : t_mem[t_rptr];

endmodule

// File: tb/tb_tcp_tuple_extractor.sv
// Directed self-checking bench for tcp_tuple_extractor: DIR_MODE=1 main instance plus a
// DIR_MODE=2 instance on the same stimulus for the canonical-ordering checks.
module tb_tcp_tuple_extractor;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr, out_rdy, tuple_ready;

  logic        in_rdy, out_wr, tuple_valid, tuple_swapped;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl, tuple_flags;
  logic [95:0] tuple_data;
  logic [31:0] num_tcp, num_tuples, num_drops, num_opt_skip;

  logic        c_in_rdy, c_out_wr, c_tuple_valid, c_tuple_swapped;
  logic [63:0] c_out_data;
  logic [7:0]  c_out_ctrl, c_tuple_flags;
  logic [95:0] c_tuple_data;
  logic [31:0] c_num_tcp, c_num_tuples, c_num_drops, c_num_opt_skip;

  int checks = 0;
  int fails  = 0;

  logic [71:0]  in_q[$], out_q[$];
  logic [104:0] tq[$], cq[$];

  logic [7:0]  pc[16];
  logic [63:0] pd[16];
  int          pn;

  localparam logic [104:0] T_SYN  = {1'b0, 8'h02, 96'h0A000001_0A000002_04D2_0050};

  always #5 clk = ~clk;

  tcp_tuple_extractor #(.DIR_MODE(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .tuple_valid(tuple_valid), .tuple_ready(tuple_ready),
    .tuple_data(tuple_data), .tuple_flags(tuple_flags), .tuple_swapped(tuple_swapped),
    .num_tcp(num_tcp), .num_tuples(num_tuples), .num_drops(num_drops),
    .num_opt_skip(num_opt_skip)
  );

  tcp_tuple_extractor #(.DIR_MODE(2)) dut_c (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(c_in_rdy), .out_data(c_out_data), .out_ctrl(c_out_ctrl), .out_wr(c_out_wr),
    .out_rdy(out_rdy), .tuple_valid(c_tuple_valid), .tuple_ready(tuple_ready),
    .tuple_data(c_tuple_data), .tuple_flags(c_tuple_flags), .tuple_swapped(c_tuple_swapped),
    .num_tcp(c_num_tcp), .num_tuples(c_num_tuples), .num_drops(c_num_drops),
    .num_opt_skip(c_num_opt_skip)
  );

  // Capture forwarded words and popped tuples once per cycle, away from the clock edge
  always @(negedge clk) begin
    #1;
    if (out_wr === 1'b1) out_q.push_back({out_ctrl, out_data});
    if (tuple_valid === 1'b1 && tuple_ready === 1'b1)
      tq.push_back({tuple_swapped, tuple_flags, tuple_data});
    if (c_tuple_valid === 1'b1 && tuple_ready === 1'b1)
      cq.push_back({c_tuple_swapped, c_tuple_flags, c_tuple_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic build_pkt(input logic [15:0] et, input logic [3:0] ihl, input logic [7:0] proto,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp,
                           input logic [7:0] fl, input int ndata);
    pc[0] = 8'hFF;
    pd[0] = 64'h0004_0000_0000_0040;
    for (int i = 1; i <= ndata; i++) pc[i] = 8'h00;
    pd[1] = 64'h0011_2233_4455_0066;
    pd[2] = {32'h7788_99AA, et, 4'h4, ihl, 8'h00};
    if (et != 16'h0800) pd[2][15:0] = 16'h0001;
    pd[3] = {16'h0028, 16'h1234, 16'h4000, 8'h40, proto};
    pd[4] = {16'hBEEF, sip, dip[31:16]};
    pd[5] = {dip[15:0], sp, dp, 16'h0000};
    pd[6] = {16'h0001, 32'h0, 8'h50, fl};
    for (int i = 7; i <= ndata; i++) pd[i] = {32'hC0DE_0000, i};
    pc[ndata] = 8'h80;
    pn = ndata + 1;
  endtask

  task automatic send_word(input logic [7:0] c, input logic [63:0] d);
    int guard = 0;
    @(negedge clk);
    while (in_rdy !== 1'b1 && guard < 200) begin
      in_wr = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      fails++;
      $display("FAIL send_timeout in_rdy got %b want 1", in_rdy);
    end
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    in_q.push_back({c, d});
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pn; i++) send_word(pc[i], pd[i]);
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_q.delete();
    out_q.delete();
    tq.delete();
    cq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || out_wr !== 1'b0 || tuple_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got rdy=%b wr=%b tv=%b want 1 0 0", in_rdy, out_wr, tuple_valid);
    end
    checks++;
    if ({num_tcp, num_tuples, num_drops, num_opt_skip} !== 128'h0 || tuple_data !== 96'h0
        || tuple_flags !== 8'h00 || tuple_swapped !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals got tcp=%0d tup=%0d drop=%0d opt=%0d data=%h want all zero",
               num_tcp, num_tuples, num_drops, num_opt_skip, tuple_data);
    end
  endtask

  task automatic test_syn();
    do_reset();
    build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02, 7);
    send_pkt();
    repeat (30) @(negedge clk);
    checks++;
    if (tq.size() != 1 || tq[0] !== T_SYN) begin
      fails++;
      $display("FAIL syn_tuple got n=%0d %h want 1 %h", tq.size(), (tq.size() > 0) ? tq[0] : 105'h0, T_SYN);
    end
    checks++;
    if (cq.size() != 1 || cq[0] !== T_SYN) begin
      fails++;
      $display("FAIL syn_tuple_canon got n=%0d %h want 1 %h", cq.size(), (cq.size() > 0) ? cq[0] : 105'h0, T_SYN);
    end
    checks++;
    if (num_tcp !== 32'd1 || num_tuples !== 32'd1 || num_drops !== 32'd0) begin
      fails++;
      $display("FAIL syn_counters got tcp=%0d tup=%0d drop=%0d want 1 1 0", num_tcp, num_tuples, num_drops);
    end
    checks++;
    if (out_q.size() != in_q.size()) begin
      fails++;
      $display("FAIL syn_fwd_len got %0d want %0d", out_q.size(), in_q.size());
    end else begin
      for (int i = 0; i < in_q.size(); i++) begin
        if (out_q[i] !== in_q[i]) begin
          fails++;
          $display("FAIL syn_fwd word %0d got %h want %h", i, out_q[i], in_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_direction();
    do_reset();
    build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h10, 7);
    send_pkt();
    build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000002, 32'h0A000001, 16'd80, 16'd1234, 8'h10, 7);
    send_pkt();
    repeat (30) @(negedge clk);
    checks++;
    if (tq.size() != 2) begin
      fails++;
      $display("FAIL dir_count got %0d want 2", tq.size());
    end else begin
      checks++;
      if (tq[0] !== {1'b1, 8'h10, 96'h0A000002_0A000001_0050_04D2}) begin
        fails++;
        $display("FAIL dir_ack_fwd got %h want %h", tq[0], {1'b1, 8'h10, 96'h0A000002_0A000001_0050_04D2});
      end
      checks++;
      if (tq[1] !== {1'b1, 8'h10, 96'h0A000001_0A000002_04D2_0050}) begin
        fails++;
        $display("FAIL dir_ack_rev got %h want %h", tq[1], {1'b1, 8'h10, 96'h0A000001_0A000002_04D2_0050});
      end
    end
    checks++;
    if (cq.size() != 2) begin
      fails++;
      $display("FAIL canon_count got %0d want 2", cq.size());
    end else begin
      checks++;
      if (cq[0] !== {1'b0, 8'h10, 96'h0A000001_0A000002_04D2_0050} ||
          cq[1] !== {1'b1, 8'h10, 96'h0A000001_0A000002_04D2_0050}) begin
        fails++;
        $display("FAIL canon_tuples got %h %h want same tuple swapped 0 then 1", cq[0], cq[1]);
      end
    end
  endtask

  task automatic test_non_tcp();
    do_reset();
    build_pkt(16'h0800, 4'd5, 8'h11, 32'h0A000001, 32'h0A000002, 16'd53, 16'd53, 8'h00, 8);
    send_pkt();
    build_pkt(16'h0806, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02, 7);
    send_pkt();
    build_pkt(16'h0800, 4'd6, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02, 8);
    send_pkt();
    repeat (30) @(negedge clk);
    checks++;
    if (tq.size() != 0 || num_tuples !== 32'd0) begin
      fails++;
      $display("FAIL nontcp_tuple got n=%0d tup=%0d want 0 0", tq.size(), num_tuples);
    end
    checks++;
    if (num_tcp !== 32'd0 || num_opt_skip !== 32'd1) begin
      fails++;
      $display("FAIL nontcp_counters got tcp=%0d opt=%0d want 0 1", num_tcp, num_opt_skip);
    end
    checks++;
    if (out_q.size() != in_q.size()) begin
      fails++;
      $display("FAIL nontcp_fwd_len got %0d want %0d", out_q.size(), in_q.size());
    end else begin
      for (int i = 0; i < in_q.size(); i++) begin
        if (out_q[i] !== in_q[i]) begin
          fails++;
          $display("FAIL nontcp_fwd word %0d got %h want %h", i, out_q[i], in_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tuple_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'(1000 + p), 16'd80, 8'h02, 7);
      send_pkt();
    end
    repeat (30) @(negedge clk);
    checks++;
    if (tuple_valid !== 1'b1 || num_tuples !== 32'd4 || num_drops !== 32'd2 || num_tcp !== 32'd6) begin
      fails++;
      $display("FAIL bp_counters got tv=%b tup=%0d drop=%0d tcp=%0d want 1 4 2 6",
               tuple_valid, num_tuples, num_drops, num_tcp);
    end
    checks++;
    if (out_q.size() != in_q.size() || out_q.size() != 48) begin
      fails++;
      $display("FAIL bp_fwd_len got %0d want %0d", out_q.size(), in_q.size());
    end else begin
      for (int i = 0; i < in_q.size(); i++) begin
        if (out_q[i] !== in_q[i]) begin
          fails++;
          $display("FAIL bp_fwd word %0d got %h want %h", i, out_q[i], in_q[i]);
          break;
        end
      end
    end
    @(negedge clk);
    tuple_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (tq.size() != 4 || tuple_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain got n=%0d tv=%b want 4 0", tq.size(), tuple_valid);
    end else begin
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (tq[p] !== {1'b0, 8'h02, 32'h0A000001, 32'h0A000002, 16'(1000 + p), 16'h0050}) begin
          fails++;
          $display("FAIL bp_order idx %0d got %h want sport %0d", p, tq[p], 1000 + p);
        end
      end
    end
  endtask

  task automatic test_random_out_rdy();
    do_reset();
    build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02, 9);
    fork
      send_pkt();
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          out_rdy = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        out_rdy = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    checks++;
    if (out_q.size() != in_q.size() || out_q.size() != 10) begin
      fails++;
      $display("FAIL rdy_fwd_len got %0d want 10", out_q.size());
    end else begin
      for (int i = 0; i < in_q.size(); i++) begin
        if (out_q[i] !== in_q[i]) begin
          fails++;
          $display("FAIL rdy_fwd word %0d got %h want %h", i, out_q[i], in_q[i]);
          break;
        end
      end
    end
    checks++;
    if (tq.size() != 1 || tq[0] !== T_SYN) begin
      fails++;
      $display("FAIL rdy_tuple got n=%0d %h want 1 %h", tq.size(), (tq.size() > 0) ? tq[0] : 105'h0, T_SYN);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02, 7);
    for (int i = 0; i < 6; i++) send_word(pc[i], pd[i]);
    @(negedge clk);
    in_wr = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_q.delete();
    out_q.delete();
    tq.delete();
    cq.delete();
    checks++;
    if (num_tcp !== 32'd0 || tuple_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear got tcp=%0d tv=%b want 0 0", num_tcp, tuple_valid);
    end
    send_word(pc[6], pd[6]);
    send_word(pc[7], pd[7]);
    @(negedge clk);
    in_wr = 1'b0;
    build_pkt(16'h0800, 4'd5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02, 7);
    send_pkt();
    repeat (30) @(negedge clk);
    checks++;
    if (tq.size() != 1 || tq[0] !== T_SYN) begin
      fails++;
      $display("FAIL midrst_tuple got n=%0d %h want 1 %h", tq.size(), (tq.size() > 0) ? tq[0] : 105'h0, T_SYN);
    end
    checks++;
    if (num_tcp !== 32'd1 || num_tuples !== 32'd1 || num_drops !== 32'd0 || num_opt_skip !== 32'd0) begin
      fails++;
      $display("FAIL midrst_counters got tcp=%0d tup=%0d drop=%0d opt=%0d want 1 1 0 0",
               num_tcp, num_tuples, num_drops, num_opt_skip);
    end
    checks++;
    if (out_q.size() != in_q.size() || out_q.size() != 10) begin
      fails++;
      $display("FAIL midrst_fwd_len got %0d want 10", out_q.size());
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_data     = 64'h0;
    in_ctrl     = 8'h00;
    in_wr       = 1'b0;
    out_rdy     = 1'b1;
    tuple_ready = 1'b1;
    test_reset();
    test_syn();
    test_direction();
    test_non_tcp();
    test_backpressure();
    test_random_out_rdy();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
